// File: rtl/estagio_mem_acesso_pkg.sv
// rtl/estagio_mem_acesso_pkg.sv - shared types and constants for the MEM stage
// Contents: FSM state encoding, default widths, MEM/WB control bundle and its bubble value.
package estagio_mem_acesso_pkg;

    localparam int DATA_W_PADRAO  = 32;
    localparam int REG_W_PADRAO   = 5;
    localparam int TIMEOUT_PADRAO = 16;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } estado_t;

    typedef struct packed {
        logic regWrite;
        logic memToReg;
    } ctrl_wb_t;

    // A bubble must never write the register file nor select memory data.
    localparam ctrl_wb_t CTRL_WB_BOLHA = '{regWrite: 1'b0, memToReg: 1'b0};

endpackage

// File: rtl/estagio_mem_acesso_registrador_mem_wb.sv
// rtl/estagio_mem_acesso_registrador_mem_wb.sv - MEM/WB pipeline register with load enable and bubble
// Ports: clock, reset (sync, active-high), carga (load), bolha (insert bubble, wins over carga),
//        ctrlIn/regDestIn/aluOutIn/memDataIn -> ctrlOut/regDest/aluOut/memData.
module registrador_mem_wb
    import estagio_mem_acesso_pkg::*;
#(
    parameter int DATA_W = DATA_W_PADRAO,
    parameter int REG_W  = REG_W_PADRAO
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              carga,
    input  logic              bolha,
    input  ctrl_wb_t          ctrlIn,
    input  logic [REG_W-1:0]  regDestIn,
    input  logic [DATA_W-1:0] aluOutIn,
    input  logic [DATA_W-1:0] memDataIn,
    output ctrl_wb_t          ctrlOut,
    output logic [REG_W-1:0]  regDest,
    output logic [DATA_W-1:0] aluOut,
    output logic [DATA_W-1:0] memData
);

    always_ff @(posedge clock) begin
        if (reset || bolha) begin
            ctrlOut <= CTRL_WB_BOLHA;
            regDest <= '0;
            aluOut  <= '0;
            memData <= '0;
        end else if (carga) begin
            ctrlOut <= ctrlIn;
            regDest <= regDestIn;
            aluOut  <= aluOutIn;
            memData <= memDataIn;
        end
    end

endmodule

// File: rtl/estagio_mem_acesso.sv
// rtl/estagio_mem_acesso.sv - MIPS MEM stage: branch resolve, data-memory handshake, MEM/WB register
// Ports: clock, reset (sync, active-high); EX/MEM inputs (pcDesvioIn, pcJumpIn, aluOutIn, reg2In,
//        zeroIn, branchIn, jumpIn, memReadIn, memWriteIn, memToRegIn, regWriteIn, regDestIn);
//        front-end redirect (ctrlDesvio, pcAlvo) and stall; data memory (memReq, memWe, memAddr,
//        memWData, memRData, memAck); MEM/WB outputs (wb*); error pulses (erroAlinhamento, erroTimeout).
module estagio_mem_acesso
    import estagio_mem_acesso_pkg::*;
#(
    parameter int DATA_W  = DATA_W_PADRAO,
    parameter int REG_W   = REG_W_PADRAO,
    parameter int TIMEOUT = TIMEOUT_PADRAO
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] pcDesvioIn,
    input  logic [DATA_W-1:0] pcJumpIn,
    input  logic [DATA_W-1:0] aluOutIn,
    input  logic [DATA_W-1:0] reg2In,
    input  logic              zeroIn,
    input  logic              branchIn,
    input  logic              jumpIn,
    input  logic              memReadIn,
    input  logic              memWriteIn,
    input  logic              memToRegIn,
    input  logic              regWriteIn,
    input  logic [REG_W-1:0]  regDestIn,
    output logic              ctrlDesvio,
    output logic [DATA_W-1:0] pcAlvo,
    output logic              stall,
    output logic              memReq,
    output logic              memWe,
    output logic [DATA_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    input  logic [DATA_W-1:0] memRData,
    input  logic              memAck,
    output logic              wbRegWrite,
    output logic              wbMemToReg,
    output logic [REG_W-1:0]  wbRegDest,
    output logic [DATA_W-1:0] wbAluOut,
    output logic [DATA_W-1:0] wbMemData,
    output logic              erroAlinhamento,
    output logic              erroTimeout
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CONT_ULTIMO = CW'(TIMEOUT - 1);

    estado_t       estado;
    logic [CW-1:0] contador;

    logic     acesso;
    logic     desalinhado;
    logic     reqIdle;
    logic     fimTimeout;
    logic     captura;
    ctrl_wb_t ctrlWbIn;
    ctrl_wb_t ctrlWbOut;
    logic [DATA_W-1:0] dadoCaptura;

    assign acesso      = memReadIn | memWriteIn;
    assign desalinhado = acesso & (aluOutIn[1:0] != 2'b00);
    assign reqIdle     = (estado == IDLE) & acesso & ~desalinhado;

    // Upstream holds its inputs while stalled, so address/data are simply passed through.
    assign memAddr  = aluOutIn;
    assign memWData = reg2In;
    assign memWe    = memWriteIn;
    assign pcAlvo   = jumpIn ? pcJumpIn : pcDesvioIn;

    assign ctrlDesvio = ~reset & ((branchIn & zeroIn) | jumpIn);
    assign memReq     = ~reset & ((estado == WAIT) | reqIdle);

    // The last unacknowledged WAIT cycle still drives memReq but releases the stall.
    assign fimTimeout = (estado == WAIT) & ~memAck & (contador == CONT_ULTIMO);
    assign stall      = memReq & ~memAck & ~fimTimeout;

    // Everything that is not a capture becomes a bubble in MEM/WB.
    assign captura     = ((estado == IDLE) & ~acesso) | (memReq & memAck);
    assign dadoCaptura = (memReq & memAck & ~memWriteIn) ? memRData : '0;
    assign ctrlWbIn    = '{regWrite: regWriteIn, memToReg: memToRegIn};

    always_ff @(posedge clock) begin
        if (reset) begin
            estado          <= IDLE;
            contador        <= '0;
            erroAlinhamento <= 1'b0;
            erroTimeout     <= 1'b0;
        end else begin
            erroAlinhamento <= (estado == IDLE) & desalinhado;
            erroTimeout     <= fimTimeout;
            case (estado)
                IDLE: begin
                    if (reqIdle && !memAck) begin
                        estado   <= WAIT;
                        contador <= CW'(1);
                    end
                end
                WAIT: begin
                    if (memAck || fimTimeout) begin
                        estado   <= IDLE;
                        contador <= '0;
                    end else begin
                        contador <= contador + CW'(1);
                    end
                end
                default: begin
                    estado   <= IDLE;
                    contador <= '0;
                end
            endcase
        end
    end

    registrador_mem_wb #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_mem_wb (
        .clock     (clock),
        .reset     (reset),
        .carga     (captura),
        .bolha     (~captura),
        .ctrlIn    (ctrlWbIn),
        .regDestIn (regDestIn),
        .aluOutIn  (aluOutIn),
        .memDataIn (dadoCaptura),
        .ctrlOut   (ctrlWbOut),
        .regDest   (wbRegDest),
        .aluOut    (wbAluOut),
        .memData   (wbMemData)
    );

    assign wbRegWrite = ctrlWbOut.regWrite;
    assign wbMemToReg = ctrlWbOut.memToReg;

endmodule

// File: tb/tb_estagio_mem_acesso.sv
// tb/tb_estagio_mem_acesso.sv - self-checking bench for estagio_mem_acesso with a MEM/WB scoreboard
module tb_estagio_mem_acesso;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pcDesvioIn, pcJumpIn, aluOutIn, reg2In, memRData;
    logic        zeroIn, branchIn, jumpIn, memReadIn, memWriteIn, memToRegIn, regWriteIn, memAck;
    logic [4:0]  regDestIn;
    logic        ctrlDesvio, stall, memReq, memWe;
    logic [31:0] pcAlvo, memAddr, memWData;
    logic        wbRegWrite, wbMemToReg, erroAlinhamento, erroTimeout;
    logic [4:0]  wbRegDest;
    logic [31:0] wbAluOut, wbMemData;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] md;
    } wb_t;

    wb_t fila[$];
    wb_t esperado;
    int  checks = 0;
    int  errors = 0;

    always #5 clock = ~clock;

    estagio_mem_acesso dut (
        .clock(clock), .reset(reset),
        .pcDesvioIn(pcDesvioIn), .pcJumpIn(pcJumpIn), .aluOutIn(aluOutIn), .reg2In(reg2In),
        .zeroIn(zeroIn), .branchIn(branchIn), .jumpIn(jumpIn), .memReadIn(memReadIn),
        .memWriteIn(memWriteIn), .memToRegIn(memToRegIn), .regWriteIn(regWriteIn),
        .regDestIn(regDestIn), .ctrlDesvio(ctrlDesvio), .pcAlvo(pcAlvo), .stall(stall),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
        .memRData(memRData), .memAck(memAck), .wbRegWrite(wbRegWrite), .wbMemToReg(wbMemToReg),
        .wbRegDest(wbRegDest), .wbAluOut(wbAluOut), .wbMemData(wbMemData),
        .erroAlinhamento(erroAlinhamento), .erroTimeout(erroTimeout)
    );

    function automatic wb_t lerWb();
        return {wbRegWrite, wbMemToReg, wbRegDest, wbAluOut, wbMemData};
    endfunction

    task automatic nop();
        pcDesvioIn = '0; pcJumpIn = '0; aluOutIn = '0; reg2In = '0; memRData = '0;
        zeroIn = 0; branchIn = 0; jumpIn = 0; memReadIn = 0; memWriteIn = 0;
        memToRegIn = 0; regWriteIn = 0; memAck = 0; regDestIn = '0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1; nop();
        memReadIn = 1; aluOutIn = 32'h80; jumpIn = 1;
        #1;
        checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL reset_memReq got %b want 0", memReq); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
        checks++; if (ctrlDesvio !== 1'b0) begin errors++; $display("FAIL reset_ctrlDesvio got %b want 0", ctrlDesvio); end
        @(posedge clock); #1;
        checks++; if (lerWb() !== '0) begin errors++; $display("FAIL reset_wb got %h want 0", lerWb()); end
        checks++; if ({erroAlinhamento, erroTimeout} !== 2'b00) begin errors++; $display("FAIL reset_erro got %b want 00", {erroAlinhamento, erroTimeout}); end
        @(negedge clock);
        nop(); reset = 0;
    endtask

    task automatic test_rtype();
        @(negedge clock);
        nop(); aluOutIn = 32'h1234; regWriteIn = 1; regDestIn = 5;
        fila.push_back('{rw: 1'b1, m2r: 1'b0, rd: 5'd5, alu: 32'h1234, md: 32'h0});
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rtype_stall got %b want 0", stall); end
        checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL rtype_memReq got %b want 0", memReq); end
        @(posedge clock); #1;
        esperado = fila.pop_front();
        checks++; if (lerWb() !== esperado) begin errors++; $display("FAIL rtype_wb got %h want %h", lerWb(), esperado); end
    endtask

    task automatic test_load_wait();
        int nStall = 0;
        @(negedge clock);
        nop(); memReadIn = 1; aluOutIn = 32'h80; regWriteIn = 1; memToRegIn = 1; regDestIn = 7;
        fila.push_back('{rw: 1'b1, m2r: 1'b1, rd: 5'd7, alu: 32'h80, md: 32'hDEADBEEF});
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin memAck = 1; memRData = 32'hDEADBEEF; end
            #1;
            if (stall === 1'b1) nStall++;
            checks++; if ({memReq, memWe} !== 2'b10) begin errors++; $display("FAIL load_req k=%0d got %b want 10", k, {memReq, memWe}); end
            checks++; if (memAddr !== 32'h80) begin errors++; $display("FAIL load_addr got %h want 80", memAddr); end
            @(posedge clock); #1;
            if (k < 3) begin
                checks++; if (wbRegWrite !== 1'b0) begin errors++; $display("FAIL load_bubble k=%0d got %b want 0", k, wbRegWrite); end
                @(negedge clock);
            end
        end
        esperado = fila.pop_front();
        checks++; if (lerWb() !== esperado) begin errors++; $display("FAIL load_wb got %h want %h", lerWb(), esperado); end
        checks++; if (nStall !== 3) begin errors++; $display("FAIL load_stall_cycles got %0d want 3", nStall); end
        @(negedge clock);
        nop();
    endtask

    task automatic test_store_zero();
        @(negedge clock);
        nop(); memWriteIn = 1; aluOutIn = 32'h40; reg2In = 32'h55; regDestIn = 3; memAck = 1;
        fila.push_back('{rw: 1'b0, m2r: 1'b0, rd: 5'd3, alu: 32'h40, md: 32'h0});
        #1;
        checks++; if ({memReq, memWe, stall} !== 3'b110) begin errors++; $display("FAIL store_ctrl got %b want 110", {memReq, memWe, stall}); end
        checks++; if ({memAddr, memWData} !== {32'h40, 32'h55}) begin errors++; $display("FAIL store_bus got %h/%h want 40/55", memAddr, memWData); end
        @(posedge clock); #1;
        esperado = fila.pop_front();
        checks++; if (lerWb() !== esperado) begin errors++; $display("FAIL store_wb got %h want %h", lerWb(), esperado); end
    endtask

    task automatic test_desvio();
        @(negedge clock);
        nop(); branchIn = 1; zeroIn = 1; pcDesvioIn = 32'h100; pcJumpIn = 32'h200;
        #1;
        checks++; if ({ctrlDesvio, pcAlvo} !== {1'b1, 32'h100}) begin errors++; $display("FAIL branch got %b/%h want 1/100", ctrlDesvio, pcAlvo); end
        jumpIn = 1; #1;
        checks++; if ({ctrlDesvio, pcAlvo} !== {1'b1, 32'h200}) begin errors++; $display("FAIL jump got %b/%h want 1/200", ctrlDesvio, pcAlvo); end
        jumpIn = 0; zeroIn = 0; #1;
        checks++; if (ctrlDesvio !== 1'b0) begin errors++; $display("FAIL branch_not_taken got %b want 0", ctrlDesvio); end
        @(negedge clock);
        nop();
    endtask

    task automatic test_desalinhado();
        @(negedge clock);
        nop(); memReadIn = 1; aluOutIn = 32'h42; regWriteIn = 1; memToRegIn = 1; regDestIn = 9; memAck = 1;
        fila.push_back('0);
        #1;
        checks++; if ({memReq, stall} !== 2'b00) begin errors++; $display("FAIL mis_req got %b want 00", {memReq, stall}); end
        @(posedge clock); #1;
        esperado = fila.pop_front();
        checks++; if (lerWb() !== esperado) begin errors++; $display("FAIL mis_wb got %h want %h", lerWb(), esperado); end
        checks++; if (erroAlinhamento !== 1'b1) begin errors++; $display("FAIL mis_erro got %b want 1", erroAlinhamento); end
        @(negedge clock);
        nop();
        @(posedge clock); #1;
        checks++; if (erroAlinhamento !== 1'b0) begin errors++; $display("FAIL mis_erro_pulse got %b want 0", erroAlinhamento); end
    endtask

    task automatic test_timeout();
        int nStall = 0;
        int nReq = 0;
        @(negedge clock);
        nop(); memReadIn = 1; aluOutIn = 32'h100; regWriteIn = 1; regDestIn = 4;
        fila.push_back('0);
        for (int k = 0; k < 16; k++) begin
            #1;
            if (stall === 1'b1) nStall++;
            if (memReq === 1'b1) nReq++;
            @(posedge clock); #1;
            if (k < 15) begin
                checks++; if (erroTimeout !== 1'b0) begin errors++; $display("FAIL timeout_early k=%0d got %b want 0", k, erroTimeout); end
                @(negedge clock);
            end
        end
        checks++; if (erroTimeout !== 1'b1) begin errors++; $display("FAIL timeout_erro got %b want 1", erroTimeout); end
        esperado = fila.pop_front();
        checks++; if (lerWb() !== esperado) begin errors++; $display("FAIL timeout_wb got %h want %h", lerWb(), esperado); end
        checks++; if (nStall !== 15) begin errors++; $display("FAIL timeout_stall_cycles got %0d want 15", nStall); end
        checks++; if (nReq !== 16) begin errors++; $display("FAIL timeout_req_cycles got %0d want 16", nReq); end
        @(negedge clock);
        nop(); #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL timeout_release got %b want 0", stall); end
        @(posedge clock); #1;
        checks++; if (erroTimeout !== 1'b0) begin errors++; $display("FAIL timeout_pulse got %b want 0", erroTimeout); end
    endtask

    task automatic test_reset_wait();
        @(negedge clock);
        nop(); memReadIn = 1; aluOutIn = 32'h200; regWriteIn = 1; regDestIn = 8;
        repeat (3) @(negedge clock);
        reset = 1; jumpIn = 1; #1;
        checks++; if ({memReq, stall, ctrlDesvio} !== 3'b000) begin errors++; $display("FAIL rstwait_comb got %b want 000", {memReq, stall, ctrlDesvio}); end
        @(posedge clock); #1;
        checks++; if (lerWb() !== '0) begin errors++; $display("FAIL rstwait_wb got %h want 0", lerWb()); end
        checks++; if ({erroAlinhamento, erroTimeout} !== 2'b00) begin errors++; $display("FAIL rstwait_erro got %b want 00", {erroAlinhamento, erroTimeout}); end
        @(negedge clock);
        nop(); reset = 0; #1;
        checks++; if ({memReq, stall} !== 2'b00) begin errors++; $display("FAIL rstwait_idle got %b want 00", {memReq, stall}); end
    endtask

    task automatic test_back_to_back();
        @(negedge clock);
        nop(); memReadIn = 1; aluOutIn = 32'h10; regWriteIn = 1; memToRegIn = 1; regDestIn = 2;
        memAck = 1; memRData = 32'hCAFEF00D;
        fila.push_back('{rw: 1'b1, m2r: 1'b1, rd: 5'd2, alu: 32'h10, md: 32'hCAFEF00D});
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_load_stall got %b want 0", stall); end
        @(posedge clock); #1;
        esperado = fila.pop_front();
        checks++; if (lerWb() !== esperado) begin errors++; $display("FAIL b2b_load_wb got %h want %h", lerWb(), esperado); end
        @(negedge clock);
        nop(); aluOutIn = 32'h77; regWriteIn = 1; regDestIn = 6; memAck = 1; memRData = 32'h1111;
        fila.push_back('{rw: 1'b1, m2r: 1'b0, rd: 5'd6, alu: 32'h77, md: 32'h0});
        #1;
        checks++; if ({memReq, stall} !== 2'b00) begin errors++; $display("FAIL b2b_rtype_req got %b want 00", {memReq, stall}); end
        @(posedge clock); #1;
        esperado = fila.pop_front();
        checks++; if (lerWb() !== esperado) begin errors++; $display("FAIL b2b_rtype_wb got %h want %h", lerWb(), esperado); end
        @(negedge clock);
        nop();
    endtask

    initial begin
        reset = 1;
        nop();
        repeat (2) @(posedge clock);
        test_reset();
        test_rtype();
        test_load_wait();
        test_store_zero();
        test_desvio();
        test_desalinhado();
        test_timeout();
        test_reset_wait();
        test_back_to_back();
        checks++; if (fila.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", fila.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
